seven_seg_mux_drv: RTL and testbench
====================================

// Module: seven_seg_mux_drv
// PURPOSE
//  Parametrised multiplexed seven-segment driver for N_DIGITS common-anode digits.
//  Adds double-buffered updates that apply only at a frame boundary, so the display
//  never tears. Adds per-digit blank and DP, leading-zero suppression, and PWM brightness.
//  Sits between the application counters/registers and the board CA..CG/DP/AN pins.
// PARAMETERS
//  N_DIGITS  8     digits scanned; an_n width; digits input = 4*N_DIGITS bits
//  TICK_DIV  1000  sys_clk cycles per PWM sub-slot (>=2)
//  PWM_W     4     brightness width; slot = TICK_DIV*2^PWM_W cycles
// PORTS
//  sys_clk    in   1           system clock (100 MHz nominal)
//  sys_rst    in   1           synchronous reset, active-high
//  wr_en      in   1           capture digits/dp_in/blank_in/bright/lz_en into staging
//  digits     in   4*N_DIGITS  hex nibble per digit; [3:0] = digit 0 (rightmost, an_n[0])
//  dp_in      in   N_DIGITS    1 = decimal point lit for that digit
//  blank_in   in   N_DIGITS    1 = digit forced dark
//  bright     in   PWM_W       brightness level; 0 = dark
//  lz_en      in   1           1 = suppress leading zeros
//  seg_n      out  7           segments, active-low, {g,f,e,d,c,b,a}
//  dp_n       out  1           decimal point, active-low
//  an_n       out  N_DIGITS    anode enables, active-low, at most one low
//  frame_start out 1           1-cycle pulse in the first cycle of each frame
//  upd_done   out  1           1-cycle pulse when staged data becomes active
// BEHAVIOUR
//  - Reset: an_n all 1, seg_n 7'h7F, dp_n 1, frame_start/upd_done 0.
//    All counters, staging and active registers clear to 0 (display dark until first write).
//  - Counters: tick_cnt 0..TICK_DIV-1; pwm_cnt (PWM_W b) increments on tick_cnt wrap.
//    dig_idx 0..N_DIGITS-1 advances when pwm_cnt wraps max->0.
//    Frame = N_DIGITS*TICK_DIV*2^PWM_W cycles.
//  - Boundary cycle: tick_cnt=TICK_DIV-1 and pwm_cnt=max and dig_idx=N_DIGITS-1.
//    In the next cycle: dig_idx=0, active<=staging, frame_start=1.
//    upd_done=1 in that cycle iff a write was pending.
//  - wr_en: staging<=inputs and sets pending. wr_en in the boundary cycle bypasses:
//    the new values become active directly and upd_done pulses.
//    Mid-frame writes never alter the frame in progress. Last write before the boundary wins.
//  - Digit lit iff pwm_cnt!=0 and pwm_cnt<=bright_act and not blank_eff[dig_idx].
//    pwm_cnt=0 is the guard sub-slot: anodes off while seg_n/dp_n change.
//    bright=max gives (2^PWM_W-1)/2^PWM_W duty; bright=0 keeps an_n all 1.
//  - blank_eff = blank_act | lz_mask. With lz_en_act, lz_mask marks contiguous zero nibbles
//    from digit N_DIGITS-1 downward. Stops at the first nonzero nibble or the first digit
//    with dp set. Digit 0 is never suppressed. lz_mask is computed from active regs.
//  - seg_n = hex decode of the active nibble (0-F, full hex font); dp_n = ~dp_act[dig_idx].
//    seg_n/dp_n are driven 7'h7F/1 while the digit is dark.
//  - All outputs registered: they reflect counter state with 1-cycle latency.
//  - sys_rst at any time, including mid-frame: next cycle equals the reset state.
//    Pending write discarded. Scanning restarts at digit 0 with frame_start one cycle after release.
// STRUCTURE
//  - Package seven_seg_pkg holds the hex-to-segment function/table (active-low {g..a}),
//    SEG_OFF=7'h7F and the lz_mask function.
//  - Sub-module seven_seg_scan_timer (TICK_DIV, PWM_W, N_DIGITS): tick/pwm/digit counters,
//    boundary strobe, guard flag.
//  - Top holds staging/active registers, blanking/PWM compare and output registers.
// TESTING (bench params N_DIGITS=4, TICK_DIV=2, PWM_W=2: slot 8 cycles, frame 32)
//  1 sys_rst high 3 cycles, then release with no write -> an_n=4'hF, seg_n=7'h7F, dp_n=1;
//    frame_start every 32 cycles.
//  2 wr_en digits=16'h1234, bright=3 -> from next frame_start, digit 0 slot has an_n=4'b1110
//    for 6 of 8 cycles with seg_n=7'h19; digit 3 slot shows seg_n=7'h79; upd_done once.
//  3 bright=1 -> each anode low exactly 2 of 8 cycles; bright=0 -> an_n stays 4'hF
//    for whole frame.
//  4 lz_en=1, digits=16'h0050 -> digits 3,2 dark, digit 1 seg_n=7'h12, digit 0 seg_n=7'h40.
//    digits=16'h0000 -> only digit 0 lit. dp_in=4'b0100 with 16'h0050 -> digit 2 lit,
//    shows 0 with dp_n=0.
//  5 wr_en 16'hABCD in boundary cycle -> next frame shows ABCD, upd_done coincides with
//    frame_start. Write 16'h5555 mid-frame -> current frame unchanged, applied at next boundary.
//  6 sys_rst pulsed during digit 2 slot -> next cycle an_n=4'hF, pending write discarded.
//    After release, scan restarts at digit 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver:
// segment font, dark pattern and leading-zero mask.
package seven_seg_pkg;

    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam int         MAX_DIGITS = 32;

    // Active-low {g,f,e,d,c,b,a}, full hex font.
    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Zero run from digit n-1 downward; a lit DP ends the run, digit 0 always shows.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(
        input logic [4*MAX_DIGITS-1:0] nib,
        input logic [MAX_DIGITS-1:0]   dp,
        input int                      n
    );
        logic run;
        lz_mask = '0;
        run     = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < n) begin
                if (run && nib[4*i +: 4] == 4'h0 && !dp[i]) begin
                    lz_mask[i] = 1'b1;
                end else begin
                    run = 1'b0;
                end
            end
        end
    endfunction

endpackage

// File: rtl/seven_seg_mux_drv_scan_timer.sv
// Tick / PWM sub-slot / digit counters for the scan, with the
// frame-boundary strobe and the guard sub-slot flag.
module seven_seg_scan_timer #(
    parameter int TICK_DIV = 1000,
    parameter int PWM_W    = 4,
    parameter int N_DIGITS = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic [(N_DIGITS > 1 ? $clog2(N_DIGITS) : 1)-1:0] dig_idx_o,
    output logic [PWM_W-1:0]     pwm_cnt_o,
    output logic                 boundary_o,
    output logic                 guard_o
);
    import seven_seg_pkg::*;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DIG_MAX  = DW'(N_DIGITS - 1);

    logic [TW-1:0]    tick_q, tick_d;
    logic [PWM_W-1:0] pwm_q, pwm_d;
    logic [DW-1:0]    dig_q, dig_d;
    logic             start_q;
    logic             tick_wrap, pwm_wrap, dig_wrap;

    assign tick_wrap = (tick_q == TICK_MAX);
    assign pwm_wrap  = tick_wrap && (pwm_q == '1);
    assign dig_wrap  = pwm_wrap && (dig_q == DIG_MAX);

    // After reset the counters hold at zero for one cycle so the
    // first frame opens with a proper boundary.
    always_comb begin
        tick_d = tick_q;
        pwm_d  = pwm_q;
        dig_d  = dig_q;
        if (!start_q) begin
            tick_d = tick_wrap ? '0 : tick_q + 1'b1;
            if (tick_wrap) begin
                pwm_d = pwm_q + 1'b1;
            end
            if (pwm_wrap) begin
                dig_d = dig_wrap ? '0 : dig_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q  <= '0;
            pwm_q   <= '0;
            dig_q   <= '0;
            start_q <= 1'b1;
        end else begin
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            dig_q   <= dig_d;
            start_q <= 1'b0;
        end
    end

    assign dig_idx_o  = dig_q;
    assign pwm_cnt_o  = pwm_q;
    assign boundary_o = start_q | dig_wrap;
    assign guard_o    = (pwm_q == '0);

endmodule

// File: rtl/seven_seg_mux_drv.sv
// Multiplexed common-anode seven-segment driver with frame-synchronous
// double buffering, blanking, DP, leading-zero suppression and PWM dimming.
module seven_seg_mux_drv #(
    parameter int N_DIGITS = 8,
    parameter int TICK_DIV = 1000,
    parameter int PWM_W    = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_en,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   blank_in,
    input  logic [PWM_W-1:0]      bright,
    input  logic                  lz_en,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_start,
    output logic                  upd_done
);
    import seven_seg_pkg::*;

    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = 6 * N_DIGITS + PWM_W + 1;

    logic [DW-1:0]    dig_idx;
    logic [PWM_W-1:0] pwm_cnt;
    logic             boundary, guard;

    seven_seg_scan_timer #(
        .TICK_DIV (TICK_DIV),
        .PWM_W    (PWM_W),
        .N_DIGITS (N_DIGITS)
    ) u_timer (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .dig_idx_o  (dig_idx),
        .pwm_cnt_o  (pwm_cnt),
        .boundary_o (boundary),
        .guard_o    (guard)
    );

    logic [CW-1:0] cfg_in, stg_q, stg_d, act_q, act_d;
    logic          pend_q, pend_d, upd_d;

    logic [4*N_DIGITS-1:0] act_dig;
    logic [N_DIGITS-1:0]   act_dp, act_blank, lz_eff, blank_eff;
    logic [PWM_W-1:0]      act_bright;
    logic                  act_lz;

    assign cfg_in = {digits, dp_in, blank_in, bright, lz_en};
    assign {act_dig, act_dp, act_blank, act_bright, act_lz} = act_q;

    // A write landing on the boundary cycle goes straight to active.
    always_comb begin
        stg_d  = stg_q;
        act_d  = act_q;
        pend_d = pend_q;
        if (wr_en) begin
            stg_d  = cfg_in;
            pend_d = 1'b1;
        end
        if (boundary) begin
            act_d  = wr_en ? cfg_in : stg_q;
            pend_d = 1'b0;
        end
        upd_d = boundary & (pend_q | wr_en);
    end

    logic [N_DIGITS-1:0] an_d, an_q;
    logic [6:0]          seg_d, seg_q;
    logic                dp_d, dp_q, fs_q, upd_q, lit;
    logic [3:0]          nib;

    always_comb begin
        lz_eff    = act_lz ? N_DIGITS'(lz_mask((4*MAX_DIGITS)'(act_dig),
                                               MAX_DIGITS'(act_dp),
                                               N_DIGITS))
                           : '0;
        blank_eff = act_blank | lz_eff;
        nib       = act_dig[4*dig_idx +: 4];
        lit       = !guard && (pwm_cnt <= act_bright) && !blank_eff[dig_idx];
        an_d      = '1;
        seg_d     = SEG_OFF;
        dp_d      = 1'b1;
        if (lit) begin
            an_d[dig_idx] = 1'b0;
            seg_d         = hex2seg(nib);
            dp_d          = ~act_dp[dig_idx];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            stg_q  <= '0;
            act_q  <= '0;
            pend_q <= 1'b0;
            an_q   <= '1;
            seg_q  <= SEG_OFF;
            dp_q   <= 1'b1;
            fs_q   <= 1'b0;
            upd_q  <= 1'b0;
        end else begin
            stg_q  <= stg_d;
            act_q  <= act_d;
            pend_q <= pend_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            fs_q   <= boundary;
            upd_q  <= upd_d;
        end
    end

    assign an_n        = an_q;
    assign seg_n       = seg_q;
    assign dp_n        = dp_q;
    assign frame_start = fs_q;
    assign upd_done    = upd_q;

endmodule

// File: tb/tb_seven_seg_mux_drv.sv
// Bench for seven_seg_mux_drv: 4 digits, 8-cycle slots, 32-cycle frames,
// checked against a frame-position reference model.
module tb_seven_seg_mux_drv;

    localparam int ND = 4;
    localparam int TD = 2;
    localparam int PW = 2;
    localparam int FRAME = 32;

    typedef struct packed {
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [1:0]  br;
        logic        lz;
    } disp_t;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        sys_rst, wr_en, lz_en;
    logic [15:0] digits;
    logic [3:0]  dp_in, blank_in;
    logic [1:0]  bright;
    logic [6:0]  seg_n;
    logic        dp_n, frame_start, upd_done;
    logic [3:0]  an_n;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seven_seg_mux_drv #(.N_DIGITS(ND), .TICK_DIV(TD), .PWM_W(PW)) dut (
        .sys_clk     (clk),
        .sys_rst     (sys_rst),
        .wr_en       (wr_en),
        .digits      (digits),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .bright      (bright),
        .lz_en       (lz_en),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .an_n        (an_n),
        .frame_start (frame_start),
        .upd_done    (upd_done)
    );

    // Expected {an_n, seg_n, dp_n} for frame position pos (0..31).
    function automatic logic [11:0] disp_out(int pos, disp_t a);
        logic [3:0] bl;
        int         dg, sub;
        logic [3:0] nb;
        bl = a.blank;
        if (a.lz) begin
            for (int d = 3; d > 0; d--) begin
                if (a.dig[4*d +: 4] != 4'h0 || a.dp[d]) break;
                bl[d] = 1'b1;
            end
        end
        dg  = pos / 8;
        sub = (pos % 8) / TD;
        nb  = a.dig[4*dg +: 4];
        if (sub == 0 || sub > int'(a.br) || bl[dg]) return {4'hF, 7'h7F, 1'b1};
        return {~(4'b0001 << dg), FONT[nb], ~a.dp[dg]};
    endfunction

    int          m_pos;
    bit          m_start, m_pend;
    disp_t       m_stg, m_act, din;
    logic [11:0] e_out;
    logic        e_fs, e_upd, bnd;

    assign din = {digits, dp_in, blank_in, bright, lz_en};
    assign bnd = m_start || (m_pos == FRAME - 1);

    always @(posedge clk) begin
        if (sys_rst) begin
            e_out   <= {4'hF, 7'h7F, 1'b1};
            e_fs    <= 1'b0;
            e_upd   <= 1'b0;
            m_pos   <= 0;
            m_start <= 1'b1;
            m_pend  <= 1'b0;
            m_stg   <= '0;
            m_act   <= '0;
        end else begin
            e_out   <= disp_out(m_pos, m_act);
            e_fs    <= bnd;
            e_upd   <= bnd && (m_pend || wr_en);
            m_pos   <= m_start ? 0 : (m_pos + 1) % FRAME;
            m_start <= 1'b0;
            if (wr_en) m_stg <= din;
            if (bnd) m_act <= wr_en ? din : m_stg;
            m_pend  <= bnd ? 1'b0 : (m_pend || wr_en);
        end
    end

    int         obs_low [4];
    logic [6:0] obs_seg [4];
    logic [3:0] obs_dp;
    int         obs_upd, obs_fs, obs_md;

    task automatic observe(input int n);
        for (int d = 0; d < 4; d++) begin
            obs_low[d] = 0;
            obs_seg[d] = 7'h7F;
        end
        obs_dp = '0; obs_upd = 0; obs_fs = 0; obs_md = 0;
        repeat (n) begin
            @(negedge clk);
            if ({an_n, seg_n, dp_n, frame_start, upd_done} !== {e_out, e_fs, e_upd})
                obs_md++;
            for (int d = 0; d < 4; d++) begin
                if (an_n[d] === 1'b0) begin
                    obs_low[d]++;
                    obs_seg[d] = seg_n;
                    if (dp_n === 1'b0) obs_dp[d] = 1'b1;
                end
            end
            if (upd_done === 1'b1) obs_upd++;
            if (frame_start === 1'b1) obs_fs++;
        end
    endtask

    task automatic drive(input disp_t d);
        {digits, dp_in, blank_in, bright, lz_en} = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic sync_frame(output bit ok);
        int k = 0;
        while (frame_start !== 1'b1 && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        ok = (frame_start === 1'b1);
    endtask

    task automatic wait_pos(input int p, output bit ok);
        int k = 0;
        while (m_pos != p && k < 2 * FRAME) begin
            @(negedge clk);
            k++;
        end
        ok = (m_pos == p);
    endtask

    function automatic disp_t rnd_disp();
        disp_t d;
        d.dig   = 16'($urandom);
        d.dp    = 4'($urandom);
        d.blank = 4'($urandom) & 4'($urandom);
        d.br    = 2'($urandom);
        d.lz    = 1'($urandom);
        return d;
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1; wr_en = 1'b0; digits = '0; dp_in = '0;
        blank_in = '0; bright = '0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({an_n, seg_n, dp_n, frame_start, upd_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL rst_state got %h want %h",
                     {an_n, seg_n, dp_n, frame_start, upd_done}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        end
        sys_rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++; $display("FAIL rst_first_fs got %b want 1", frame_start);
        end
        observe(2 * FRAME);
        n_cmp++;
        if (obs_fs != 2) begin
            n_bad++; $display("FAIL rst_fs_period got %0d want 2", obs_fs);
        end
        n_cmp++;
        if (obs_low[0] + obs_low[1] + obs_low[2] + obs_low[3] != 0) begin
            n_bad++; $display("FAIL rst_dark got %0d lit cycles want 0",
                              obs_low[0] + obs_low[1] + obs_low[2] + obs_low[3]);
        end
        n_cmp++;
        if (obs_md != 0) begin
            n_bad++; $display("FAIL rst_model got %0d diffs want 0", obs_md);
        end
    endtask

    task automatic test_write();
        bit ok;
        drive('{dig: 16'h1234, dp: 4'h0, blank: 4'h0, br: 2'd3, lz: 1'b0});
        sync_frame(ok);
        n_cmp++;
        if (!ok || upd_done !== 1'b1) begin
            n_bad++; $display("FAIL wr_upd_at_fs got fs=%b upd=%b want 1 1", frame_start, upd_done);
        end
        observe(FRAME);
        n_cmp++;
        if (obs_low[0] != 6 || obs_seg[0] !== 7'h19) begin
            n_bad++; $display("FAIL wr_digit0 got %0d/%h want 6/19", obs_low[0], obs_seg[0]);
        end
        n_cmp++;
        if (obs_seg[3] !== 7'h79) begin
            n_bad++; $display("FAIL wr_digit3 got %h want 79", obs_seg[3]);
        end
        n_cmp++;
        if (obs_upd != 0 || obs_md != 0) begin
            n_bad++; $display("FAIL wr_once got upd=%0d diffs=%0d want 0 0", obs_upd, obs_md);
        end
    endtask

    task automatic test_bright();
        bit    ok;
        int    lv [4];
        disp_t d;
        lv = '{1, 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3))};
        foreach (lv[i]) begin
            d       = rnd_disp();
            d.blank = '0;
            d.lz    = 1'b0;
            d.br    = 2'(lv[i]);
            drive(d);
            sync_frame(ok);
            observe(FRAME);
            for (int g = 0; g < ND; g++) begin
                n_cmp++;
                if (!ok || obs_low[g] != 2 * lv[i]) begin
                    n_bad++; $display("FAIL bright%0d_d%0d got %0d want %0d",
                                      lv[i], g, obs_low[g], 2 * lv[i]);
                end
            end
            n_cmp++;
            if (obs_md != 0) begin
                n_bad++; $display("FAIL bright_model got %0d diffs want 0", obs_md);
            end
        end
    endtask

    task automatic test_lz();
        bit          ok;
        logic [15:0] cd [3];
        logic [3:0]  cdp [3];
        logic [3:0]  cm [3];
        logic [3:0]  mask;
        disp_t       d;
        cd  = '{16'h0050, 16'h0000, 16'h0050};
        cdp = '{4'b0000, 4'b0000, 4'b0100};
        cm  = '{4'b0011, 4'b0001, 4'b0111};
        for (int i = 0; i < 3; i++) begin
            drive('{dig: cd[i], dp: cdp[i], blank: 4'h0, br: 2'd3, lz: 1'b1});
            sync_frame(ok);
            observe(FRAME);
            mask = {obs_low[3] > 0, obs_low[2] > 0, obs_low[1] > 0, obs_low[0] > 0};
            n_cmp++;
            if (!ok || mask !== cm[i]) begin
                n_bad++; $display("FAIL lz%0d_mask got %b want %b", i, mask, cm[i]);
            end
            n_cmp++;
            if (obs_seg[0] !== 7'h40 || (i == 0 && obs_seg[1] !== 7'h12)) begin
                n_bad++; $display("FAIL lz%0d_seg got %h_%h want 12_40", i, obs_seg[1], obs_seg[0]);
            end
        end
        n_cmp++;
        if (obs_seg[2] !== 7'h40 || obs_dp !== 4'b0100) begin
            n_bad++; $display("FAIL lz_dp got seg=%h dp=%b want 40 0100", obs_seg[2], obs_dp);
        end
        repeat (4) begin
            d     = rnd_disp();
            d.dig = d.dig & {{4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}},
                             {4{$urandom_range(0, 1) == 1}}, {4{$urandom_range(0, 1) == 1}}};
            d.lz  = 1'b1;
            drive(d);
            sync_frame(ok);
            observe(FRAME);
            n_cmp++;
            if (!ok || obs_md != 0) begin
                n_bad++; $display("FAIL lz_rand dig=%h got %0d diffs want 0", d.dig, obs_md);
            end
        end
    endtask

    task automatic test_boundary();
        bit ok;
        wait_pos(FRAME - 1, ok);
        drive('{dig: 16'hABCD, dp: 4'h0, blank: 4'h0, br: 2'd3, lz: 1'b0});
        n_cmp++;
        if (!ok || frame_start !== 1'b1 || upd_done !== 1'b1) begin
            n_bad++; $display("FAIL bnd_bypass got fs=%b upd=%b want 1 1", frame_start, upd_done);
        end
        observe(10);
        n_cmp++;
        if (obs_seg[0] !== 7'h21) begin
            n_bad++; $display("FAIL bnd_d0 got %h want 21", obs_seg[0]);
        end
        drive('{dig: 16'h5555, dp: 4'h0, blank: 4'h0, br: 2'd3, lz: 1'b0});
        observe(FRAME - 11);
        n_cmp++;
        if ({obs_seg[3], obs_seg[2], obs_seg[1]} !== {7'h08, 7'h03, 7'h46}) begin
            n_bad++; $display("FAIL bnd_keep got %h_%h_%h want 08_03_46",
                              obs_seg[3], obs_seg[2], obs_seg[1]);
        end
        n_cmp++;
        if (obs_upd != 1 || obs_fs != 1 || upd_done !== 1'b1) begin
            n_bad++; $display("FAIL bnd_apply got upd=%0d fs=%0d want 1 1", obs_upd, obs_fs);
        end
        observe(FRAME);
        n_cmp++;
        if ({obs_seg[3], obs_seg[2], obs_seg[1], obs_seg[0]} !== {4{7'h12}} || obs_md != 0) begin
            n_bad++; $display("FAIL bnd_next got %h_%h_%h_%h diffs=%0d want 12_12_12_12 0",
                              obs_seg[3], obs_seg[2], obs_seg[1], obs_seg[0], obs_md);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        drive('{dig: 16'h7777, dp: 4'hF, blank: 4'h0, br: 2'd3, lz: 1'b0});
        sync_frame(ok);
        drive('{dig: 16'h9999, dp: 4'h0, blank: 4'h0, br: 2'd3, lz: 1'b0});
        wait_pos(19, ok);
        sys_rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (!ok || {an_n, seg_n, dp_n, frame_start, upd_done} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL rstmid_state got %h want %h",
                              {an_n, seg_n, dp_n, frame_start, upd_done}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        end
        sys_rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_fs got %b want 1", frame_start);
        end
        observe(2 * FRAME);
        n_cmp++;
        if (obs_low[0] + obs_low[1] + obs_low[2] + obs_low[3] != 0 || obs_upd != 0) begin
            n_bad++; $display("FAIL rstmid_discard got lit=%0d upd=%0d want 0 0",
                              obs_low[0] + obs_low[1] + obs_low[2] + obs_low[3], obs_upd);
        end
        drive('{dig: 16'h0008, dp: 4'h0, blank: 4'h0, br: 2'd3, lz: 1'b0});
        sync_frame(ok);
        observe(8);
        n_cmp++;
        if (!ok || obs_low[0] != 6 || obs_seg[0] !== 7'h00) begin
            n_bad++; $display("FAIL rstmid_d0 got %0d/%h want 6/00", obs_low[0], obs_seg[0]);
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 20 * FRAME; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({an_n, seg_n, dp_n, frame_start, upd_done} !== {e_out, e_fs, e_upd}) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d got %h want %h", c,
                         {an_n, seg_n, dp_n, frame_start, upd_done}, {e_out, e_fs, e_upd});
            end
            wr_en = ($urandom_range(0, 5) == 0);
            if (wr_en) {digits, dp_in, blank_in, bright, lz_en} = rnd_disp();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_bright();
        test_lz();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
